// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] SAMPLE_MID = 4'd7;
    localparam logic [3:0] SAMPLE_END = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep metastability synchroniser resetting to 1 (idle line level).
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 16x-oversampled UART receiver presenting bytes on an AXI-Stream register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_clk,
    input  logic       rxd,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                 rxs;
    rx_state_t            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic [7:0]           tdata_q, tdata_d;
    logic                 tvalid_q, tvalid_d;
    logic                 frame_err_q, overrun_q, overrun_d;
    logic                 load;
    logic                 mid, fin;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rxd),
        .q_o (rxs)
    );

    assign mid = rx_clk && tick_q == SAMPLE_MID;
    assign fin = rx_clk && tick_q == SAMPLE_END;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d, pbad_q, pbad_d, parity_err_q;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = rx_clk ? tick_q + 4'd1 : tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        pbad_d  = pbad_q;
`endif
        case (state_q)
            IDLE: begin
                tick_d  = '0;
                state_d = rxs ? IDLE : START;
            end
            START: if (mid) begin
                tick_d  = '0;
                bit_d   = '0;
                state_d = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                par_d   = 1'b0;
`endif
            end
            DATA: if (fin) begin
                tick_d  = '0;
                shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == LAST_BIT) ? AFTER_DATA : DATA;
`ifdef UART_RX_PARITY_EN
                par_d   = par_q ^ rxs;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (fin) begin
                tick_d  = '0;
                par_d   = par_q ^ rxs;
                state_d = STOP;
            end
`endif
            STOP: if (fin) begin
                tick_d  = '0;
                done_d  = rxs;
                ferr_d  = !rxs;
                state_d = rxs ? IDLE : BREAK;
`ifdef UART_RX_PARITY_EN
                pbad_d  = par_q;
`endif
            end
            BREAK: state_d = rxs ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    // A completed byte lands one clock after the stop sample; the slot is free if empty or draining now.
    assign load      = done_q && (!tvalid_q || m_axis_tready);
    assign tvalid_d  = load || (tvalid_q && !m_axis_tready);
    assign tdata_d   = load ? 8'(shift_q) : tdata_q;
    assign overrun_d = done_q && !load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            frame_err_q <= ferr_q;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q        <= 1'b0;
            pbad_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            pbad_q       <= pbad_d;
            parity_err_q <= done_q && pbad_q;
        end
    end

    assign parity_err = parity_err_q;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule
